// File: rtl/keypad_fifo.sv
// keypad_fifo: polls the keypad scanner every POLL_DIV+1 cycles and buffers
// each valid key code in a small circular FIFO. The CPU reads the FIFO
// through an IOR_N/CS_N port, and the end of each read access pops the head.
//
// Optional feature macro: KEYFIFO_OVERWRITE_EN
//   defined   - a push into a full FIFO (no pop) discards the oldest entry
//   undefined - a push into a full FIFO (no pop) drops the incoming code
// In both cases ovf is set.
module keypad_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int POLL_DIV   = 1000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] key_dat_i,
  output logic        key_rd_n_o,
  output logic        key_cs_n_o,
  input  logic        IOR_N,
  input  logic        CS_N,
  output logic [15:0] wb_dat_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = $clog2(POLL_DIV);
  localparam logic [CNT_W-1:0]    POLL_LAST = CNT_W'(POLL_DIV - 1);
  localparam logic [DEPTH_LOG2:0] FULL_CNT  = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [0:0] {
    P_WAIT = 1'b0,
    P_RD   = 1'b1
  } poll_state_t;

  poll_state_t           state;
  logic [CNT_W-1:0]      poll_cnt;

  logic [3:0]            mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  ovf;
  logic                  rd_act_q;

  logic                  rd_act;
  logic                  rd_end;
  logic                  nonempty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  wr_en;
  logic                  rd_adv;
  logic                  ovf_set;
  logic [3:0]            key_code;
  logic [3:0]            head;
  logic [4:0]            count_ext;
  logic                  unused_key_bits;

  // Upper status bits (keysta and padding) carry nothing this block needs.
  assign unused_key_bits = ^key_dat_i[15:5];

  // The scanner chip select always travels with its read strobe.
  assign key_cs_n_o = key_rd_n_o;

  // Decode CPU access edges, push/pop requests and FIFO status flags.
  always_comb begin
    rd_act   = !IOR_N && !CS_N;
    rd_end   = rd_act_q && !rd_act;
    nonempty = (count != {(DEPTH_LOG2+1){1'b0}});
    full     = (count == FULL_CNT);
    key_code = key_dat_i[3:0];
    push     = (state == P_RD) && key_dat_i[4];
    pop      = rd_end && nonempty;
  end

  // Resolve what the storage does this cycle, including the full-FIFO policy.
  always_comb begin
    wr_en   = 1'b0;
    rd_adv  = 1'b0;
    ovf_set = push && full && !pop;
`ifdef KEYFIFO_OVERWRITE_EN
    if (push) begin
      wr_en = 1'b1;
    end else begin
      wr_en = 1'b0;
    end
    if (pop || (push && full)) begin
      rd_adv = 1'b1;
    end else begin
      rd_adv = 1'b0;
    end
`else
    if (push && (!full || pop)) begin
      wr_en = 1'b1;
    end else begin
      wr_en = 1'b0;
    end
    if (pop) begin
      rd_adv = 1'b1;
    end else begin
      rd_adv = 1'b0;
    end
`endif
  end

  // Poll sequencer: count out the wait period, then strobe the scanner once.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= P_WAIT;
      poll_cnt   <= '0;
      key_rd_n_o <= 1'b1;
    end else begin
      case (state)
        P_WAIT: begin
          if (poll_cnt == POLL_LAST) begin
            poll_cnt   <= '0;
            state      <= P_RD;
            key_rd_n_o <= 1'b0;
          end else begin
            poll_cnt   <= poll_cnt + 1'b1;
            key_rd_n_o <= 1'b1;
          end
        end
        P_RD: begin
          state      <= P_WAIT;
          key_rd_n_o <= 1'b1;
        end
        default: begin
          state      <= P_WAIT;
          poll_cnt   <= '0;
          key_rd_n_o <= 1'b1;
        end
      endcase
    end
  end

  // FIFO bookkeeping: pointers, occupancy, overflow flag and read tracking.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      rd_act_q <= 1'b0;
    end else begin
      rd_act_q <= rd_act;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + 1'b1;
      end else begin
        rd_ptr <= rd_ptr;
      end
      if (wr_en && !rd_adv) begin
        count <= count + 1'b1;
      end else if (!wr_en && rd_adv) begin
        count <= count - 1'b1;
      end else begin
        count <= count;
      end
      // A new overflow outranks the clear from a finishing read.
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (rd_end) begin
        ovf <= 1'b0;
      end else begin
        ovf <= ovf;
      end
    end
  end

  // Key code storage; contents need no reset since the head is masked when empty.
  always_ff @(posedge wb_clk_i) begin
    if (wr_en && !wb_rst_i) begin
      mem[wr_ptr] <= key_code;
    end
  end

  // CPU read word built straight from FIFO state so it holds for the whole access.
  always_comb begin
    count_ext               = 5'b00000;
    count_ext[DEPTH_LOG2:0] = count;
    if (nonempty) begin
      head = mem[rd_ptr];
    end else begin
      head = 4'h0;
    end
    wb_dat_o = {nonempty, ovf, 1'b0, count_ext, 4'b0000, head};
  end

endmodule
